// File: rtl/uart_rx_bit_sampler.sv
// +--------------------------------------------------------------------------+
// | uart_rx_bit_sampler: UART RX oversampling edge/bit counters + bit sampler |
// | Option macro: UART_RX_MAJORITY_VOTE_EN (three-sample majority vote).      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module uart_rx_bit_sampler (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx_in,
  input  logic       i_enable,
  input  logic       i_data_samp_en,
  input  logic       i_par_en,
  input  logic [5:0] i_prescale,
  output logic [4:0] o_edge_cnt,
  output logic [3:0] o_bit_cnt,
  output logic       o_sampled_bit,
  output logic       o_sample_valid
);

  localparam logic [3:0] c_LAST_BIT_PAR   = 4'd10;
  localparam logic [3:0] c_LAST_BIT_NOPAR = 4'd9;

  logic [4:0] r_edge_cnt;
  logic [3:0] r_bit_cnt;
  logic       r_sampled_bit;
  logic       r_sample_valid;

  logic [5:0] w_p;
  logic [5:0] w_mid;
  logic [5:0] w_edge6;
  logic       w_wrap;
  logic [3:0] w_last_bit;
  logic       w_capture;

  always_comb begin
    w_p = 6'd8;
    case (i_prescale)
      6'd16:   w_p = 6'd16;
      6'd32:   w_p = 6'd32;
      default: w_p = 6'd8;
    endcase
  end

  // Six-bit compare so that P=32 wraps at 31 without overflowing the 5-bit count.
  assign w_edge6    = {1'b0, r_edge_cnt};
  assign w_mid      = {1'b0, w_p[5:1]};
  assign w_wrap     = (w_edge6 == (w_p - 6'd1));
  assign w_last_bit = i_par_en ? c_LAST_BIT_PAR : c_LAST_BIT_NOPAR;
  assign w_capture  = i_enable & i_data_samp_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_edge_cnt <= 5'd0;
      r_bit_cnt  <= 4'd0;
    end else if (!i_enable) begin
      r_edge_cnt <= 5'd0;
      r_bit_cnt  <= 4'd0;
    end else if (w_wrap) begin
      r_edge_cnt <= 5'd0;
      // >= keeps the counter recoverable if PAR_EN changes mid-frame.
      if (r_bit_cnt >= w_last_bit)
        r_bit_cnt <= 4'd0;
      else
        r_bit_cnt <= r_bit_cnt + 4'd1;
    end else begin
      r_edge_cnt <= r_edge_cnt + 5'd1;
    end
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] r_samp;
  logic [1:0] r_samp_ok;
  logic       w_majority;

  assign w_majority = (r_samp[0] & r_samp[1]) | (r_samp[0] & i_rx_in) | (r_samp[1] & i_rx_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_samp         <= 2'b00;
      r_samp_ok      <= 2'b00;
      r_sampled_bit  <= 1'b1;
      r_sample_valid <= 1'b0;
    end else begin
      r_sample_valid <= 1'b0;
      if (!w_capture) begin
        r_samp_ok <= 2'b00;
      end else if (w_edge6 == (w_mid - 6'd1)) begin
        r_samp[0]    <= i_rx_in;
        r_samp_ok[0] <= 1'b1;
      end else if (w_edge6 == w_mid) begin
        r_samp[1]    <= i_rx_in;
        r_samp_ok[1] <= r_samp_ok[0];
      end else if (w_edge6 == (w_mid + 6'd1)) begin
        // Third capture is the live line; decide only if the first two survived.
        if (r_samp_ok[1]) begin
          r_sampled_bit  <= w_majority;
          r_sample_valid <= 1'b1;
        end
        r_samp_ok <= 2'b00;
      end
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sampled_bit  <= 1'b1;
      r_sample_valid <= 1'b0;
    end else begin
      r_sample_valid <= 1'b0;
      if (w_capture && (w_edge6 == w_mid)) begin
        r_sampled_bit  <= i_rx_in;
        r_sample_valid <= 1'b1;
      end
    end
  end
`endif

  assign o_edge_cnt     = r_edge_cnt;
  assign o_bit_cnt      = r_bit_cnt;
  assign o_sampled_bit  = r_sampled_bit;
  assign o_sample_valid = r_sample_valid;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_bit_sampler.sv
// +--------------------------------------------------------------------------+
// | tb_uart_rx_bit_sampler: directed self-checking bench for the RX sampler. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx_bit_sampler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       en  = 1'b0;
  logic       dse = 1'b0;
  logic       par = 1'b0;
  logic [5:0] ps  = 6'd8;
  logic [4:0] o_edge_cnt;
  logic [3:0] o_bit_cnt;
  logic       o_sampled_bit;
  logic       o_sample_valid;

  int n_pass  = 0;
  int n_total = 0;
  int n_pulse = 0;
  logic q_exp[$];
  logic [10:0] frame_bits;
  logic [7:0]  data_byte;
  logic        exp_bit;

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int c_VOFF = 2;
  localparam logic c_GLITCH_BIT = 1'b0;
`else
  localparam int c_VOFF = 1;
  localparam logic c_GLITCH_BIT = 1'b1;
`endif

  uart_rx_bit_sampler dut (
    .clk            (clk),
    .rst            (rst),
    .i_rx_in        (rx),
    .i_enable       (en),
    .i_data_samp_en (dse),
    .i_par_en       (par),
    .i_prescale     (ps),
    .o_edge_cnt     (o_edge_cnt),
    .o_bit_cnt      (o_bit_cnt),
    .o_sampled_bit  (o_sampled_bit),
    .o_sample_valid (o_sample_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_edge_cnt", 32'(o_edge_cnt), 32'd0);
    chk("rst_bit_cnt", 32'(o_bit_cnt), 32'd0);
    chk("rst_sampled_bit", 32'(o_sampled_bit), 32'd1);
    chk("rst_sample_valid", 32'(o_sample_valid), 32'd0);
    rst = 1'b0;
    step();

    // Reset asserted mid-frame at BIT_CNT=4, EDGE_CNT=5
    ps = 6'd8; dse = 1'b1; rx = 1'b0; en = 1'b1;
    repeat (37) step();
    chk("mid_edge_cnt", 32'(o_edge_cnt), 32'd5);
    chk("mid_bit_cnt", 32'(o_bit_cnt), 32'd4);
    chk("mid_sampled_bit", 32'(o_sampled_bit), 32'd0);
    rst = 1'b1;
    #1;
    chk("async_rst_edge_cnt", 32'(o_edge_cnt), 32'd0);
    chk("async_rst_bit_cnt", 32'(o_bit_cnt), 32'd0);
    chk("async_rst_sampled_bit", 32'(o_sampled_bit), 32'd1);
    chk("async_rst_sample_valid", 32'(o_sample_valid), 32'd0);
    #1;
    rst = 1'b0;
    step();
    chk("restart_edge_cnt", 32'(o_edge_cnt), 32'd1);
    en = 1'b0;
    step();

    // Full frame with parity, byte 0xA5, even parity
    data_byte  = 8'hA5;
    frame_bits = {1'b1, ^data_byte, data_byte, 1'b0};
    ps = 6'd8; par = 1'b1; dse = 1'b1; n_pulse = 0;
    for (int t = 0; t <= 88; t++) begin
      if (o_sample_valid) begin
        n_pulse++;
        chk("frame_valid_edge", 32'(o_edge_cnt), 32'(4 + c_VOFF));
        if (q_exp.size() == 0) begin
          n_total++;
          $error("FAIL frame_scoreboard: observed unexpected pulse expected none");
        end else begin
          exp_bit = q_exp.pop_front();
          chk("frame_sampled_bit", 32'(o_sampled_bit), 32'(exp_bit));
        end
      end
      if (t % 8 == 0) begin
        chk("frame_bit_cnt", 32'(o_bit_cnt), 32'((t / 8) % 11));
        chk("frame_edge_cnt", 32'(o_edge_cnt), 32'd0);
      end
      if (t < 88) begin
        if (t % 8 == 0) q_exp.push_back(frame_bits[t / 8]);
        rx = frame_bits[t / 8];
        en = 1'b1;
        step();
      end
    end
    chk("frame_pulse_count", 32'(n_pulse), 32'd11);
    chk("frame_queue_empty", 32'(q_exp.size()), 32'd0);

    // Frame without parity at PRESCALE=32
    en = 1'b0;
    step();
    par = 1'b0; ps = 6'd32; dse = 1'b0; rx = 1'b1; n_pulse = 0;
    for (int t = 0; t <= 320; t++) begin
      if (o_sample_valid) n_pulse++;
      if (t == 31) chk("p32_edge_max", 32'(o_edge_cnt), 32'd31);
      if (t == 319) begin
        chk("p32_last_bit", 32'(o_bit_cnt), 32'd9);
        chk("p32_last_edge", 32'(o_edge_cnt), 32'd31);
      end
      if (t == 320) begin
        chk("p32_wrap_bit", 32'(o_bit_cnt), 32'd0);
        chk("p32_wrap_edge", 32'(o_edge_cnt), 32'd0);
      end
      if (t < 320) begin
        en = 1'b1;
        step();
      end
    end
    chk("p32_no_pulses", 32'(n_pulse), 32'd0);

    // Glitch at EDGE_CNT=8, PRESCALE=16, line otherwise low
    en = 1'b0;
    step();
    ps = 6'd16; dse = 1'b1;
    for (int t = 0; t < 16; t++) begin
      if (t == 8 + c_VOFF) begin
        chk("glitch_valid", 32'(o_sample_valid), 32'd1);
        chk("glitch_valid_edge", 32'(o_edge_cnt), 32'(8 + c_VOFF));
        chk("glitch_sampled_bit", 32'(o_sampled_bit), 32'(c_GLITCH_BIT));
      end
      rx = (t == 8);
      en = 1'b1;
      step();
    end

    // Illegal PRESCALE behaves like 8
    en = 1'b0;
    step();
    ps = 6'd12; dse = 1'b0; rx = 1'b1;
    for (int t = 0; t < 10; t++) begin
      if (t == 7) chk("ill_edge_max", 32'(o_edge_cnt), 32'd7);
      if (t == 8) begin
        chk("ill_edge_wrap", 32'(o_edge_cnt), 32'd0);
        chk("ill_bit_cnt", 32'(o_bit_cnt), 32'd1);
      end
      en = 1'b1;
      step();
    end

    // ENABLE drops at BIT_CNT=3, EDGE_CNT=7
    en = 1'b0;
    step();
    ps = 6'd8; dse = 1'b1; rx = 1'b0;
    for (int t = 0; t < 31; t++) begin
      en = 1'b1;
      step();
    end
    chk("drop_pre_bit", 32'(o_bit_cnt), 32'd3);
    chk("drop_pre_edge", 32'(o_edge_cnt), 32'd7);
    en = 1'b0;
    step();
    chk("drop_edge_cnt", 32'(o_edge_cnt), 32'd0);
    chk("drop_bit_cnt", 32'(o_bit_cnt), 32'd0);
    chk("drop_sampled_bit", 32'(o_sampled_bit), 32'd0);
    chk("drop_sample_valid", 32'(o_sample_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx_bit_sampler.md
# uart_rx_bit_sampler

Oversampling front end of the UART receiver. It runs the edge counter and bit counter that pace the receive control FSM, and it recovers each serial bit from RX_IN by sampling around the bit centre. It sits directly upstream of the receive FSM, which consumes EDGE_CNT, BIT_CNT and SAMPLED_BIT. The start, parity and stop checkers and the deserializer also consume SAMPLED_BIT.

## Interface
- No parameters. Widths are fixed to match the receive FSM.
- Ports:
- CLK  in  1  receiver oversampling clock.
- RST  in  1  asynchronous reset, active-high.
- RX_IN  in  1  serial line, already synchronized to CLK; idle high.
- ENABLE  in  1  from the FSM; 1 = frame in progress, counters run.
- DATA_SAMP_EN  in  1  from the FSM; 1 = sampler may capture.
- PAR_EN  in  1  1 = the frame carries a parity bit.
- PRESCALE  in  6  oversampling ratio; legal values are 8, 16 and 32.
- EDGE_CNT  out  5  CLK edges elapsed within the current bit, 0..PRESCALE-1.
- BIT_CNT  out  4  current bit index: 0 = start, 1..8 = data, 9 = parity or stop, 10 = stop.
- SAMPLED_BIT  out  1  decided value of the current bit.
- SAMPLE_VALID  out  1  one-cycle pulse, SAMPLED_BIT was updated on the previous edge.

## Operation
- Illegal PRESCALE (anything other than 8, 16 or 32) is treated as 8. The value in use, P, is decoded combinationally every cycle.
- Edge counter:
  - ENABLE=0: EDGE_CNT is cleared to 0 on the next edge.
  - ENABLE=1 and EDGE_CNT = P-1: EDGE_CNT wraps to 0.
  - ENABLE=1 otherwise: EDGE_CNT increments by 1.
  - The compare uses 6-bit arithmetic with EDGE_CNT zero-extended, so P=32 wraps correctly at 31.
- Bit counter:
  - Frame length L = 11 when PAR_EN=1, L = 10 when PAR_EN=0.
  - ENABLE=0: BIT_CNT is cleared to 0.
  - On each EDGE_CNT wrap, BIT_CNT increments. At index L-1 it wraps to 0 instead, which is the FSM's end-of-stop indication.
  - PAR_EN is sampled at every wrap. Changing it mid-frame is unsupported but must not hang the counter: any BIT_CNT ≥ L-1 wraps to 0.
- Sampler (mid point M = P/2):
  - Captures RX_IN only when DATA_SAMP_EN=1 and ENABLE=1.
  - Majority mode: capture RX_IN at EDGE_CNT = M-1, M and M+1. On the edge that ends EDGE_CNT = M+1, SAMPLED_BIT takes the majority of the three captures.
  - SAMPLE_VALID is high during the following cycle, i.e. while EDGE_CNT = M+2.
  - If DATA_SAMP_EN drops between captures, the partial captures are discarded and SAMPLED_BIT holds.
  - SAMPLED_BIT holds its value between decisions and across frames.
- RST asserted mid-frame forces all state to reset values immediately. The next frame starts cleanly once ENABLE is reasserted after RST is released.

## Timing
- Reset values: EDGE_CNT=0, BIT_CNT=0, SAMPLED_BIT=1, SAMPLE_VALID=0; internal capture registers are 0.
- All outputs are registered. There is no combinational path from any input to any output.
- Counter latency is one cycle from ENABLE rising: the first edge with ENABLE=1 moves EDGE_CNT from 0 to 1.
- SAMPLED_BIT is stable from EDGE_CNT = M+2 through P-1. Consumers that strobe at EDGE_CNT = P-1 therefore see the current bit's value.
- If ENABLE falls on the same edge that EDGE_CNT would wrap, the clear wins: both counters go to 0.
- Bit period is exactly P cycles. A full frame is L·P cycles.

## Configuration
- Macro: UART_RX_MAJORITY_VOTE_EN.
- Defined: three-sample majority vote as described under Operation.
- Undefined: a single capture at EDGE_CNT = M sets SAMPLED_BIT directly. SAMPLE_VALID then pulses while EDGE_CNT = M+1. The unused capture registers are not built.
- Counter behaviour is identical in both builds.

## Test plan
- Reset during a frame: PRESCALE=8, ENABLE=1, RST pulsed at BIT_CNT=4, EDGE_CNT=5 → all outputs read 0/0/1/0 in the same cycle. EDGE_CNT restarts from 1 on the first edge after RST falls with ENABLE=1.
- Full frame with parity: PRESCALE=8, PAR_EN=1, ENABLE held high, byte 0xA5 sent LSB first with even parity → BIT_CNT steps 0..10 then 0 after 88 cycles. SAMPLED_BIT sequence is 0,1,0,1,0,0,1,0,1,0,1. There are 11 SAMPLE_VALID pulses.
- Frame without parity: PRESCALE=32, PAR_EN=0 → EDGE_CNT reaches 31. BIT_CNT wraps from 9 to 0 after 320 cycles.
- Glitch rejection (majority build): PRESCALE=16, line low for the bit, RX_IN forced high only at EDGE_CNT=8 → SAMPLED_BIT=0, SAMPLE_VALID high at EDGE_CNT=10. The same stimulus in the single-sample build → SAMPLED_BIT=1.
- Illegal prescale: PRESCALE=12 → EDGE_CNT wraps at 7, identical to PRESCALE=8.
- ENABLE drop: ENABLE falls at BIT_CNT=3, EDGE_CNT=7 with PRESCALE=8 → next cycle both counters are 0 and SAMPLED_BIT holds its last value.
